// File: rtl/dmem_dump_arbiter.sv
// Data-memory port arbiter: passes pipeline accesses through, or stalls the
// pipeline and streams the whole data memory, MSB byte first, to the debug UART.
module dmem_dump_arbiter #(
   parameter int NB_WIDTH = 32,
   parameter int NB_ADDR  = 9,
   parameter int NB_DATA  = 8
) (
   input  logic                i_clk,
   input  logic                i_reset,
   input  logic [NB_WIDTH-1:0] i_pipe_mem_addr,
   input  logic [NB_WIDTH-1:0] i_pipe_mem_data,
   input  logic                i_pipe_mem_read,
   input  logic                i_pipe_mem_write,
   input  logic [2:0]          i_pipe_BHW,
   input  logic                i_dump_start,
   input  logic [NB_WIDTH-1:0] i_mem_read_data,
   input  logic                i_tx_ready,
   output logic [NB_WIDTH-1:0] o_mem_addr,
   output logic [NB_WIDTH-1:0] o_mem_data,
   output logic                o_mem_read,
   output logic                o_mem_write,
   output logic [2:0]          o_mem_BHW,
   output logic                o_dunit_r_data,
   output logic                o_pipe_stall,
   output logic [NB_DATA-1:0]  o_tx_byte,
   output logic                o_tx_valid,
   output logic                o_dump_busy,
   output logic                o_dump_done
);

   localparam int NB_CNT = NB_ADDR - 2;
   localparam logic [NB_CNT-1:0] LAST_WORD = '1;

   typedef enum logic [2:0] {IDLE, RD, CAP, SEND, DONE} state_t;

   state_t              state;
   logic                pending;
   logic [NB_CNT-1:0]   word_cnt;
   logic [1:0]          byte_idx;
   logic [NB_WIDTH-1:0] shift;

   assign o_tx_byte = shift[NB_WIDTH-1 -: NB_DATA];

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state          <= IDLE;
         pending        <= 1'b0;
         word_cnt       <= '0;
         byte_idx       <= '0;
         shift          <= '0;
         o_tx_valid     <= 1'b0;
         o_dump_busy    <= 1'b0;
         o_dump_done    <= 1'b0;
         o_pipe_stall   <= 1'b0;
         o_dunit_r_data <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               // A start seen during a pipeline access waits for the first free cycle.
               if (pending && !i_pipe_mem_read && !i_pipe_mem_write) begin
                  state          <= RD;
                  pending        <= 1'b0;
                  word_cnt       <= '0;
                  o_pipe_stall   <= 1'b1;
                  o_dump_busy    <= 1'b1;
                  o_dunit_r_data <= 1'b1;
               end else if (i_dump_start) begin
                  pending <= 1'b1;
               end
            end
            RD: begin
               state          <= CAP;
               o_dunit_r_data <= 1'b0;
            end
            CAP: begin
               state      <= SEND;
               shift      <= i_mem_read_data;
               byte_idx   <= '0;
               o_tx_valid <= 1'b1;
            end
            SEND: begin
               if (i_tx_ready) begin
                  shift    <= {shift[NB_WIDTH-NB_DATA-1:0], {NB_DATA{1'b0}}};
                  byte_idx <= byte_idx + 2'd1;
                  if (byte_idx == 2'd3) begin
                     o_tx_valid <= 1'b0;
                     if (word_cnt == LAST_WORD) begin
                        state       <= DONE;
                        o_dump_done <= 1'b1;
                     end else begin
                        state          <= RD;
                        word_cnt       <= word_cnt + NB_CNT'(1);
                        o_dunit_r_data <= 1'b1;
                     end
                  end
               end
            end
            DONE: begin
               state        <= IDLE;
               o_dump_done  <= 1'b0;
               o_pipe_stall <= 1'b0;
               o_dump_busy  <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Memory port: transparent to the pipeline when idle, owned by the dump otherwise.
   always_comb begin
      o_mem_addr  = '0;
      o_mem_data  = '0;
      o_mem_read  = 1'b0;
      o_mem_write = 1'b0;
      o_mem_BHW   = 3'b011;
      if (state == IDLE) begin
         o_mem_addr  = i_pipe_mem_addr;
         o_mem_data  = i_pipe_mem_data;
         o_mem_read  = i_pipe_mem_read;
         o_mem_write = i_pipe_mem_write;
         o_mem_BHW   = i_pipe_BHW;
      end else begin
         o_mem_addr[NB_ADDR-1:0] = {word_cnt, 2'b00};
         o_mem_read              = (state == RD);
      end
   end

endmodule

// File: tb/tb_dmem_dump_arbiter.sv
// Bench for dmem_dump_arbiter: transaction-level dump model, per-cycle compare,
// and literal checks on the streamed bytes and dump addresses.
module tb_dmem_dump_arbiter;

   logic        clk;
   logic        i_reset;
   logic [31:0] i_pipe_mem_addr, i_pipe_mem_data;
   logic        i_pipe_mem_read, i_pipe_mem_write;
   logic [2:0]  i_pipe_BHW;
   logic        i_dump_start;
   logic [31:0] mem_rdata;
   logic        i_tx_ready;
   logic [31:0] o_mem_addr, o_mem_data;
   logic        o_mem_read, o_mem_write;
   logic [2:0]  o_mem_BHW;
   logic        o_dunit_r_data, o_pipe_stall;
   logic [7:0]  o_tx_byte;
   logic        o_tx_valid, o_dump_busy, o_dump_done;

   dmem_dump_arbiter dut (
      .i_clk(clk), .i_reset(i_reset),
      .i_pipe_mem_addr(i_pipe_mem_addr), .i_pipe_mem_data(i_pipe_mem_data),
      .i_pipe_mem_read(i_pipe_mem_read), .i_pipe_mem_write(i_pipe_mem_write),
      .i_pipe_BHW(i_pipe_BHW), .i_dump_start(i_dump_start),
      .i_mem_read_data(mem_rdata), .i_tx_ready(i_tx_ready),
      .o_mem_addr(o_mem_addr), .o_mem_data(o_mem_data),
      .o_mem_read(o_mem_read), .o_mem_write(o_mem_write), .o_mem_BHW(o_mem_BHW),
      .o_dunit_r_data(o_dunit_r_data), .o_pipe_stall(o_pipe_stall),
      .o_tx_byte(o_tx_byte), .o_tx_valid(o_tx_valid),
      .o_dump_busy(o_dump_busy), .o_dump_done(o_dump_done)
   );

   int vectors = 0;
   int fails = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Memory image served to dump reads; wrong-cycle data is random garbage.
   logic [31:0] mem [128];
   always @(posedge clk)
      mem_rdata <= o_mem_read ? mem[o_mem_addr[8:2]] : $urandom;

   // Behavioural dump model: one word = 2 fetch cycles then 4 offered bytes.
   bit m_busy = 0, m_pending = 0, m_done = 0, chk_on = 0;
   int m_lat = 0, m_word = 0, m_nbyte = 0;

   always @(posedge clk) begin
      chk_on <= 1;
      if (i_reset) begin
         m_busy = 0; m_pending = 0; m_done = 0;
      end else if (!m_busy) begin
         if (m_pending && !i_pipe_mem_read && !i_pipe_mem_write) begin
            m_busy = 1; m_pending = 0; m_word = 0; m_lat = 2; m_nbyte = 0;
         end else if (i_dump_start) begin
            m_pending = 1;
         end
      end else if (m_done) begin
         m_busy = 0; m_done = 0;
      end else if (m_lat > 0) begin
         m_lat--;
      end else if (i_tx_ready) begin
         m_nbyte++;
         if (m_nbyte == 4) begin
            if (m_word == 127) m_done = 1;
            else begin m_word++; m_lat = 2; m_nbyte = 0; end
         end
      end
   end

   // Per-cycle compare plus stream capture.
   logic [7:0]  rx_q[$];
   logic [31:0] addr_q[$];
   int          done_cnt = 0;
   logic [31:0] cmp_w;
   bit          rd_now, offer;

   always @(negedge clk) begin
      if (chk_on) begin
         if (!m_busy) begin
            chk("pass_addr", o_mem_addr, i_pipe_mem_addr);
            chk("pass_data", o_mem_data, i_pipe_mem_data);
            chk("pass_read", 32'(o_mem_read), 32'(i_pipe_mem_read));
            chk("pass_write", 32'(o_mem_write), 32'(i_pipe_mem_write));
            chk("pass_bhw", 32'(o_mem_BHW), 32'(i_pipe_BHW));
            chk("idle_ctrl", {27'd0, o_pipe_stall, o_dunit_r_data, o_tx_valid, o_dump_busy, o_dump_done}, 32'd0);
            chk("idle_byte", 32'(o_tx_byte), 32'd0);
         end else begin
            rd_now = !m_done && m_lat == 2;
            offer  = !m_done && m_lat == 0;
            chk("busy_stall", {30'd0, o_pipe_stall, o_dump_busy}, 32'd3);
            chk("busy_write", 32'(o_mem_write), 32'd0);
            chk("busy_read", 32'(o_mem_read), 32'(rd_now));
            chk("busy_dunit", 32'(o_dunit_r_data), 32'(rd_now));
            chk("busy_done", 32'(o_dump_done), 32'(m_done));
            chk("busy_valid", 32'(o_tx_valid), 32'(offer));
            if (rd_now) chk("dump_addr", o_mem_addr, 32'(m_word * 4));
            if (offer) begin
               cmp_w = mem[m_word];
               chk("tx_byte", 32'(o_tx_byte), 32'(8'(cmp_w >> (8 * (3 - m_nbyte)))));
            end
         end
      end
      if (!i_reset) begin
         if (o_tx_valid && i_tx_ready) rx_q.push_back(o_tx_byte);
         if (o_mem_read && o_dunit_r_data) addr_q.push_back(o_mem_addr);
      end
      if (o_dump_done) done_cnt++;
   end

   // Ready generator: 0 always, 1 one-on/three-off, 2 random.
   int rdy_mode = 0;
   int cyc = 0;
   initial begin
      i_tx_ready = 1;
      forever begin
         @(posedge clk); #1;
         cyc++;
         case (rdy_mode)
            1: i_tx_ready = (cyc % 4 == 0);
            2: i_tx_ready = $urandom_range(1, 0) == 1;
            default: i_tx_ready = 1;
         endcase
      end
   end

   // Random pipeline traffic and stray starts while busy (ignored by design).
   bit traffic_on = 0, kick = 0;
   initial begin
      forever begin
         @(posedge clk); #2;
         if (traffic_on) begin
            i_pipe_mem_addr  = $urandom;
            i_pipe_mem_data  = $urandom;
            i_pipe_BHW       = 3'($urandom);
            i_pipe_mem_read  = $urandom_range(3, 0) == 0;
            i_pipe_mem_write = $urandom_range(3, 0) == 1;
            i_dump_start     = kick || (m_busy && !m_done && $urandom_range(7, 0) == 0);
         end
      end
   end

   task automatic pipe_idle();
      i_pipe_mem_addr = 0; i_pipe_mem_data = 0; i_pipe_BHW = 0;
      i_pipe_mem_read = 0; i_pipe_mem_write = 0; i_dump_start = 0;
   endtask

   task automatic pulse_start();
      i_dump_start = 1;
      @(posedge clk); #1;
      i_dump_start = 0;
   endtask

   task automatic wait_done(input int max_cyc);
      int d0 = done_cnt;
      for (int k = 0; k < max_cyc; k++) begin
         @(posedge clk);
         if (done_cnt > d0) break;
      end
      #1;
      chk("dump_finished", 32'(done_cnt > d0), 32'd1);
      @(posedge clk); @(posedge clk); #1;
      chk("done_pulses", 32'(done_cnt - d0), 32'd1);
   endtask

   logic [7:0] head [8] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00, 8'h00, 8'h00, 8'hFF};
   logic [7:0] ref_q[$];
   int bad, d0;

   initial begin
      pipe_idle();
      i_reset = 1;
      for (int i = 0; i < 128; i++) mem[i] = 0;
      mem[0] = 32'hDEADBEEF;
      mem[1] = 32'h000000FF;

      // Reset values
      @(posedge clk); @(posedge clk);
      @(negedge clk);
      chk("rst_ctrl", {27'd0, o_pipe_stall, o_dunit_r_data, o_tx_valid, o_dump_busy, o_dump_done}, 32'd0);
      chk("rst_byte", 32'(o_tx_byte), 32'd0);
      chk("rst_memrw", {30'd0, o_mem_read, o_mem_write}, 32'd0);
      @(posedge clk); #1;
      i_reset = 0;

      // Passthrough store
      i_pipe_mem_write = 1; i_pipe_mem_addr = 12; i_pipe_mem_data = 32'hDEADBEEF; i_pipe_BHW = 3'b011;
      @(negedge clk);
      chk("pt_addr", o_mem_addr, 32'd12);
      chk("pt_data", o_mem_data, 32'hDEADBEEF);
      chk("pt_wr_bhw", {28'd0, o_mem_write, o_mem_BHW}, 32'hB);
      chk("pt_stall", {30'd0, o_pipe_stall, o_dunit_r_data}, 32'd0);
      @(posedge clk); #1;
      pipe_idle();
      traffic_on = 1;
      repeat (40) @(posedge clk);
      #1; traffic_on = 0; pipe_idle();

      // Full dump, ready always high
      rx_q.delete(); addr_q.delete();
      pulse_start();
      wait_done(3000);
      chk("full_len", rx_q.size(), 32'd512);
      chk("full_addrs", addr_q.size(), 32'd128);
      bad = 0;
      for (int i = 0; i < 8 && i < rx_q.size(); i++) if (rx_q[i] !== head[i]) bad++;
      for (int i = 8; i < rx_q.size(); i++) if (rx_q[i] !== 8'h00) bad++;
      chk("full_bytes_bad", bad, 0);
      bad = 0;
      for (int i = 0; i < addr_q.size(); i++) if (addr_q[i] !== 32'(i * 4)) bad++;
      chk("full_addr_bad", bad, 0);
      ref_q = rx_q;
      chk("post_stall", 32'(o_pipe_stall), 32'd0);

      // Backpressure: 1 on, 3 off
      rdy_mode = 1;
      rx_q.delete(); addr_q.delete();
      pulse_start();
      wait_done(6000);
      chk("bp_len", rx_q.size(), 32'd512);
      bad = 0;
      for (int i = 0; i < rx_q.size() && i < ref_q.size(); i++) if (rx_q[i] !== ref_q[i]) bad++;
      chk("bp_bytes_bad", bad, 0);
      rdy_mode = 0;

      // Deferred start during a store
      rx_q.delete(); addr_q.delete();
      i_pipe_mem_write = 1; i_pipe_mem_addr = 32'h40; i_pipe_mem_data = 32'h12345678; i_pipe_BHW = 3'b011;
      i_dump_start = 1;
      @(negedge clk);
      chk("def_store", {o_mem_write, o_mem_addr[30:0]}, 32'h80000040);
      chk("def_data", o_mem_data, 32'h12345678);
      @(posedge clk); #1;
      i_dump_start = 0;
      repeat (2) begin
         @(negedge clk);
         chk("def_nostall", {30'd0, o_pipe_stall, o_dunit_r_data}, 32'd0);
         @(posedge clk); #1;
      end
      i_pipe_mem_write = 0;
      @(negedge clk);
      chk("def_idle_cyc", {30'd0, o_pipe_stall, o_dunit_r_data}, 32'd0);
      @(negedge clk);
      chk("def_rd_cyc", {30'd0, o_pipe_stall, o_dunit_r_data}, 32'd3);
      chk("def_rd_addr", o_mem_addr, 32'd0);
      @(posedge clk); #1;
      wait_done(3000);
      chk("def_len", rx_q.size(), 32'd512);

      // Random memory, random ready, random pipeline traffic
      for (int i = 0; i < 128; i++) mem[i] = $urandom;
      rx_q.delete(); addr_q.delete();
      rdy_mode = 2; traffic_on = 1;
      kick = 1;
      @(posedge clk); #1;
      kick = 0;
      wait_done(8000);
      traffic_on = 0; pipe_idle(); rdy_mode = 0;
      chk("rand_len", rx_q.size(), 32'd512);

      // Abort mid-word 3, then restart
      rx_q.delete(); addr_q.delete();
      pulse_start();
      for (int k = 0; k < 300; k++) begin
         if (rx_q.size() >= 14) break;
         @(posedge clk); #1;
      end
      chk("abort_reached", rx_q.size(), 32'd14);
      d0 = done_cnt;
      i_reset = 1;
      @(posedge clk); #1;
      i_reset = 0;
      @(negedge clk);
      chk("abort_idle", {29'd0, o_pipe_stall, o_tx_valid, o_dump_busy}, 32'd0);
      repeat (5) @(posedge clk);
      #1;
      chk("abort_nodone", done_cnt, d0);
      chk("abort_nobytes", rx_q.size(), 32'd14);
      rx_q.delete(); addr_q.delete();
      pulse_start();
      wait_done(3000);
      chk("restart_len", rx_q.size(), 32'd512);
      chk("restart_addr0", addr_q.size() > 0 ? addr_q[0] : 32'hFFFFFFFF, 32'd0);
      chk("restart_word0", rx_q.size() >= 4 ? {rx_q[0], rx_q[1], rx_q[2], rx_q[3]} : 32'hX, mem[0]);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
      $finish;
   end

endmodule

// File: doc/dmem_dump_arbiter.md
Name: dmem_dump_arbiter

Overview:
Arbitrates the data memory port between the pipeline MEM stage and the debug unit. In normal operation it passes pipeline accesses straight through. On a debug dump request it stalls the pipeline and walks the whole data memory one word at a time. Each word is streamed out as 4 bytes over a valid/ready handshake to the debug UART transmitter.

Parameters:
NB_WIDTH, 32, data/address word width
NB_ADDR, 9, data memory byte-address bits (2^NB_ADDR bytes, 2^(NB_ADDR-2) words)
NB_DATA, 8, width of the streamed byte

Ports:
i_clk  in  1  clock
i_reset  in  1  synchronous reset, active-high
i_pipe_mem_addr  in  NB_WIDTH  pipeline byte address
i_pipe_mem_data  in  NB_WIDTH  pipeline store data
i_pipe_mem_read  in  1  pipeline load request
i_pipe_mem_write  in  1  pipeline store request
i_pipe_BHW  in  3  pipeline size/sign code
i_dump_start  in  1  debug unit dump request (pulse or level)
i_mem_read_data  in  NB_WIDTH  memory read data, valid 1 cycle after o_mem_read
i_tx_ready  in  1  UART transmitter ready
o_mem_addr  out  NB_WIDTH  address to memory
o_mem_data  out  NB_WIDTH  store data to memory
o_mem_read  out  1  read enable to memory
o_mem_write  out  1  write enable to memory
o_mem_BHW  out  3  size code to memory
o_dunit_r_data  out  1  debug-read select to memory
o_pipe_stall  out  1  freeze pipeline
o_tx_byte  out  NB_DATA  byte to transmitter
o_tx_valid  out  1  o_tx_byte valid
o_dump_busy  out  1  dump in progress
o_dump_done  out  1  one-cycle pulse at dump end

Behaviour:
- Reset: FSM=IDLE, word counter=0, pending=0, all registered outputs 0. The following are 0: o_tx_valid, o_tx_byte, o_dump_busy, o_dump_done, o_pipe_stall, o_dunit_r_data. Reset is checked before all else and aborts a dump in any state without a done pulse.
- States: IDLE, RD, CAP, SEND, DONE.
- IDLE:
  - Memory outputs combinationally equal the pipeline inputs.
  - o_pipe_stall=0, o_dunit_r_data=0.
  - i_dump_start sets pending.
  - When pending=1 and i_pipe_mem_read=0 and i_pipe_mem_write=0 in a cycle, go to RD next cycle, clear pending, and set counter=0.
  - A start coincident with a pipeline access is deferred, never dropped. The pipeline access completes that cycle.
- RD (1 cycle):
  - o_mem_addr = counter*4, zero-extended.
  - o_mem_read=1, o_mem_write=0, o_mem_BHW=3'b011 (word), o_dunit_r_data=1.
  - Next state: CAP.
- CAP (1 cycle): latch i_mem_read_data into a 32-bit shift register, clear byte index, go to SEND.
- SEND:
  - o_tx_valid=1, o_tx_byte = shift register [31:24] (MSB first).
  - The byte is stable while i_tx_ready=0.
  - On valid&ready: shift left by 8 and increment byte index.
  - After the 4th accepted byte: if counter = 2^(NB_ADDR-2)-1 go to DONE; else counter+1 and go to RD.
  - o_tx_valid drops for at least RD+CAP (2 cycles) between words.
- DONE (1 cycle): o_dump_done=1, then IDLE.
- In all states except IDLE:
  - o_pipe_stall=1 and o_dump_busy=1.
  - Pipeline requests are ignored: o_mem_write=0 except via RD, which never writes.
  - o_mem_read=0 outside RD.
- i_dump_start is ignored while busy. It is not queued.
- Counter is NB_ADDR-2 bits. No wrap past the last word; the dump terminates.
- Default byte count per dump = 512; words per dump = 128.

Test Plan:
- Reset values: hold i_reset 2 cycles -> every output 0, o_pipe_stall=0.
- Pipeline passthrough: idle, pipeline writes addr=12 data=DEADBEEF BHW=011 -> o_mem_* equal inputs the same cycle, o_dunit_r_data=0, no stall.
- Full dump: memory model word0=DEADBEEF, word1=000000FF, rest 0, i_tx_ready=1.
  - Bytes DE AD BE EF 00 00 00 FF then 504 zeros are sent.
  - o_mem_addr sequence is 0,4,...,508.
  - One o_dump_done pulse, then stall clears.
- Backpressure: toggle i_tx_ready 1 cycle on, 3 off -> each byte held stable until accepted; no byte lost or duplicated; same 512-byte sequence.
- Deferred start: pulse i_dump_start while i_pipe_mem_write=1 -> store completes unmodified; RD begins the first cycle after the pipeline goes idle.
- Abort and restart: assert i_reset mid-word (after 2 bytes of word 3) -> IDLE next cycle, no done pulse. A new start dumps from address 0.
